// File: rtl/mem_pkg.sv
// Shared definitions for the memory access controller: RV32 width codes,
// access-size helper and the grant/state encodings.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {GNT_FETCH, GNT_DATA} grant_e;
    typedef enum logic {IDLE, ACCESS} state_e;

    function automatic logic [2:0] size_from_func3(input logic [2:0] func3);
        logic [2:0] size;
        case (func3)
            F3_H, F3_HU: size = 3'd2;
            F3_W:        size = 3'd4;
            default:     size = 3'd1;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/mem_req_check.sv
// Combinational legality check of one request: alignment, data-region range
// and func3 validity. Fetches only need word alignment.
module mem_req_check
    import mem_pkg::*;
#(
    parameter int ADDR_W    = 9,
    parameter int DATA_SPAN = 256
) (
    input  logic              is_fetch,
    input  logic              we,
    input  logic [2:0]        func3,
    input  logic [ADDR_W-1:0] addr,
    output logic              err
);

    localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(DATA_SPAN);

    logic            illegal_f3;
    logic            misaligned;
    logic            out_of_range;
    logic [ADDR_W:0] last_byte;

    always_comb begin
        illegal_f3   = 1'b0;
        misaligned   = 1'b0;
        out_of_range = 1'b0;
        last_byte    = {1'b0, addr} + {{(ADDR_W-2){1'b0}}, size_from_func3(func3)}
                       - (ADDR_W+1)'(1);
        err          = 1'b0;

        if (is_fetch) begin
            err = (addr[1:0] != 2'b00);
        end else begin
            case (func3)
                F3_B, F3_H, F3_W, F3_BU, F3_HU: illegal_f3 = 1'b0;
                default:                        illegal_f3 = 1'b1;
            endcase
            // Unsigned load widths have no store counterpart.
            if (we && (func3 > F3_W)) begin
                illegal_f3 = 1'b1;
            end
            case (func3)
                F3_H, F3_HU: misaligned = addr[0];
                F3_W:        misaligned = (addr[1:0] != 2'b00);
                default:     misaligned = 1'b0;
            endcase
            out_of_range = (last_byte >= SPAN);
            err = illegal_f3 | misaligned | out_of_range;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Round-robin fetch/data arbiter driving a single-ported unified memory:
// accept in IDLE, one ACCESS cycle of strobes, response pulse the cycle after.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 32,
    parameter int DATA_SPAN = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_valid,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_ready,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    output logic              f_err,
    input  logic              d_valid,
    input  logic              d_we,
    input  logic [2:0]        d_func3,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic              mem_fetch,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_func3,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e            state_q, state_d;
    grant_e            last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [2:0]        req_func3_q, req_func3_d;
    logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
    logic              req_we_q, req_we_d;
    logic              req_fetch_q, req_fetch_d;
    logic              req_err_q, req_err_d;
    logic              f_rvalid_q, f_rvalid_d;
    logic [DATA_W-1:0] f_rdata_q, f_rdata_d;
    logic              f_err_q, f_err_d;
    logic              d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              d_err_q, d_err_d;

    logic f_chk_err, d_chk_err;
    logic gnt_fetch, idle_ok, f_acc, d_acc, in_access, strobe_ok;

    mem_req_check #(.ADDR_W(ADDR_W), .DATA_SPAN(DATA_SPAN)) u_f_check (
        .is_fetch (1'b1),
        .we       (1'b0),
        .func3    (F3_W),
        .addr     (f_addr),
        .err      (f_chk_err)
    );

    mem_req_check #(.ADDR_W(ADDR_W), .DATA_SPAN(DATA_SPAN)) u_d_check (
        .is_fetch (1'b0),
        .we       (d_we),
        .func3    (d_func3),
        .addr     (d_addr),
        .err      (d_chk_err)
    );

    // With no contention the grant still points somewhere so exactly one ready is up in IDLE.
    always_comb begin
        if (f_valid && d_valid) begin
            gnt_fetch = (last_grant_q == GNT_DATA);
        end else if (f_valid) begin
            gnt_fetch = 1'b1;
        end else if (d_valid) begin
            gnt_fetch = 1'b0;
        end else begin
            gnt_fetch = (last_grant_q == GNT_DATA);
        end
        idle_ok = rst_n && (state_q == IDLE);
        f_ready = idle_ok && gnt_fetch;
        d_ready = idle_ok && !gnt_fetch;
        f_acc   = f_valid && f_ready;
        d_acc   = d_valid && d_ready;
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        req_addr_d   = req_addr_q;
        req_func3_d  = req_func3_q;
        req_wdata_d  = req_wdata_q;
        req_we_d     = req_we_q;
        req_fetch_d  = req_fetch_q;
        req_err_d    = req_err_q;
        f_rvalid_d   = 1'b0;
        f_rdata_d    = '0;
        f_err_d      = 1'b0;
        d_rvalid_d   = 1'b0;
        d_rdata_d    = '0;
        d_err_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (f_acc) begin
                    state_d      = ACCESS;
                    last_grant_d = GNT_FETCH;
                    req_addr_d   = f_addr;
                    req_func3_d  = F3_W;
                    req_wdata_d  = '0;
                    req_we_d     = 1'b0;
                    req_fetch_d  = 1'b1;
                    req_err_d    = f_chk_err;
                end else if (d_acc) begin
                    state_d      = ACCESS;
                    last_grant_d = GNT_DATA;
                    req_addr_d   = d_addr;
                    req_func3_d  = d_func3;
                    req_wdata_d  = d_wdata;
                    req_we_d     = d_we;
                    req_fetch_d  = 1'b0;
                    req_err_d    = d_chk_err;
                end
            end
            ACCESS: begin
                state_d = IDLE;
                if (req_fetch_q) begin
                    f_rvalid_d = 1'b1;
                    f_err_d    = req_err_q;
                    f_rdata_d  = req_err_q ? '0 : mem_rdata;
                end else begin
                    d_rvalid_d = 1'b1;
                    d_err_d    = req_err_q;
                    d_rdata_d  = (req_err_q || req_we_q) ? '0 : mem_rdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_access = (state_q == ACCESS);
        strobe_ok = in_access && !req_err_q;
        mem_read  = strobe_ok && (req_fetch_q || !req_we_q);
        mem_write = strobe_ok && req_we_q && !req_fetch_q;
        mem_fetch = strobe_ok && req_fetch_q;
        mem_addr  = in_access ? req_addr_q  : '0;
        mem_wdata = in_access ? req_wdata_q : '0;
        mem_func3 = in_access ? req_func3_q : 3'b000;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= GNT_DATA;
            f_rvalid_q   <= 1'b0;
            f_rdata_q    <= '0;
            f_err_q      <= 1'b0;
            d_rvalid_q   <= 1'b0;
            d_rdata_q    <= '0;
            d_err_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            f_rvalid_q   <= f_rvalid_d;
            f_rdata_q    <= f_rdata_d;
            f_err_q      <= f_err_d;
            d_rvalid_q   <= d_rvalid_d;
            d_rdata_q    <= d_rdata_d;
            d_err_q      <= d_err_d;
        end
    end

    // Request latches are only observed while in ACCESS, so they need no reset.
    always_ff @(posedge clk) begin
        req_addr_q  <= req_addr_d;
        req_func3_q <= req_func3_d;
        req_wdata_q <= req_wdata_d;
        req_we_q    <= req_we_d;
        req_fetch_q <= req_fetch_d;
        req_err_q   <= req_err_d;
    end

    assign f_rvalid = f_rvalid_q;
    assign f_rdata  = f_rdata_q;
    assign f_err    = f_err_q;
    assign d_rvalid = d_rvalid_q;
    assign d_rdata  = d_rdata_q;
    assign d_err    = d_err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: reset, single fetch/load/store
// transactions, error cases and fetch/data alternation under contention.
module tb_mem_access_ctrl;

    localparam int ADDR_W    = 9;
    localparam int DATA_W    = 32;
    localparam int DATA_SPAN = 256;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              f_valid;
    logic [ADDR_W-1:0] f_addr;
    logic              f_ready, f_rvalid, f_err;
    logic [DATA_W-1:0] f_rdata;
    logic              d_valid, d_we;
    logic [2:0]        d_func3;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ready, d_rvalid, d_err;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_read, mem_write, mem_fetch;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [2:0]        mem_func3;
    logic [DATA_W-1:0] mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DATA_SPAN(DATA_SPAN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .f_valid   (f_valid),
        .f_addr    (f_addr),
        .f_ready   (f_ready),
        .f_rvalid  (f_rvalid),
        .f_rdata   (f_rdata),
        .f_err     (f_err),
        .d_valid   (d_valid),
        .d_we      (d_we),
        .d_func3   (d_func3),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ready   (d_ready),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_fetch (mem_fetch),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_func3 (mem_func3),
        .mem_rdata (mem_rdata)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_flags"},
              {60'd0, f_ready, d_ready, f_rvalid, d_rvalid}, 64'd0);
        check({tag, "_flags2"},
              {59'd0, f_err, d_err, mem_read, mem_write, mem_fetch}, 64'd0);
        check({tag, "_buses"},
              {63'd0, |{f_rdata, d_rdata, mem_addr, mem_wdata, mem_func3}}, 64'd0);
    endtask

    // One request from IDLE through its response; expected strobes and
    // response data follow from the request kind and the expected error.
    task automatic do_req(input string tag, input logic is_f, input logic we,
                          input logic [2:0] f3, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wdata,
                          input logic [DATA_W-1:0] mrdata, input logic exp_err);
        logic exp_read, exp_write;
        logic [DATA_W-1:0] exp_rdata;
        exp_read  = !exp_err && (is_f || !we);
        exp_write = !exp_err && !is_f && we;
        exp_rdata = (exp_err || (!is_f && we)) ? '0 : mrdata;
        if (is_f) begin
            f_valid = 1'b1;
            f_addr  = addr;
        end else begin
            d_valid = 1'b1;
            d_we    = we;
            d_func3 = f3;
            d_addr  = addr;
            d_wdata = wdata;
        end
        #1;
        check({tag, "_ready"}, {63'd0, (is_f ? f_ready : d_ready)}, 64'd1);
        step();
        f_valid   = 1'b0;
        d_valid   = 1'b0;
        mem_rdata = mrdata;
        #1;
        check({tag, "_mem_read"},  {63'd0, mem_read},  {63'd0, exp_read});
        check({tag, "_mem_write"}, {63'd0, mem_write}, {63'd0, exp_write});
        check({tag, "_mem_fetch"}, {63'd0, mem_fetch}, {63'd0, (is_f && !exp_err)});
        if (!exp_err) begin
            check({tag, "_mem_addr"},  {55'd0, mem_addr},  {55'd0, addr});
            check({tag, "_mem_func3"}, {61'd0, mem_func3}, {61'd0, (is_f ? 3'b010 : f3)});
            if (exp_write) begin
                check({tag, "_mem_wdata"}, {32'd0, mem_wdata}, {32'd0, wdata});
            end
        end
        step();
        mem_rdata = '0;
        #1;
        if (is_f) begin
            check({tag, "_rvalid"}, {63'd0, f_rvalid}, 64'd1);
            check({tag, "_err"},    {63'd0, f_err},    {63'd0, exp_err});
            check({tag, "_rdata"},  {32'd0, f_rdata},  {32'd0, exp_rdata});
        end else begin
            check({tag, "_rvalid"}, {63'd0, d_rvalid}, 64'd1);
            check({tag, "_err"},    {63'd0, d_err},    {63'd0, exp_err});
            check({tag, "_rdata"},  {32'd0, d_rdata},  {32'd0, exp_rdata});
        end
        step();
        check({tag, "_pulse_end"}, {62'd0, f_rvalid, d_rvalid}, 64'd0);
    endtask

    // Contention pattern from a fresh reset: F accepted, D, F, D, one accept per 2 cycles.
    logic [7:0] exp_fr  = 8'b0001_0001;
    logic [7:0] exp_dr  = 8'b0100_0100;
    logic [7:0] exp_frv = 8'b0100_0100;
    logic [7:0] exp_drv = 8'b0001_0000;

    initial begin
        int n_resp;
        rst_n     = 1'b0;
        f_valid   = 1'b0;
        f_addr    = '0;
        d_valid   = 1'b0;
        d_we      = 1'b0;
        d_func3   = '0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_rdata = '0;

        repeat (3) step();
        check_all_zero("por");
        rst_n = 1'b1;

        // Accept a fetch, then reset in the middle of its ACCESS cycle.
        f_valid = 1'b1;
        f_addr  = 9'h004;
        #1;
        check("pre_rst_fready", {63'd0, f_ready}, 64'd1);
        step();
        f_valid = 1'b0;
        #1;
        check("pre_rst_access", {63'd0, mem_read}, 64'd1);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_all_zero("mid_rst");
        end
        rst_n = 1'b1;

        f_valid   = 1'b1;
        f_addr    = 9'h020;
        d_valid   = 1'b1;
        d_we      = 1'b0;
        d_func3   = 3'b010;
        d_addr    = 9'h010;
        mem_rdata = 32'h0000_1111;
        n_resp    = 0;
        for (int k = 0; k < 8; k++) begin
            #1;
            check($sformatf("alt_fready_%0d", k), {63'd0, f_ready}, {63'd0, exp_fr[k]});
            check($sformatf("alt_dready_%0d", k), {63'd0, d_ready}, {63'd0, exp_dr[k]});
            check($sformatf("alt_frv_%0d", k), {63'd0, f_rvalid}, {63'd0, exp_frv[k]});
            check($sformatf("alt_drv_%0d", k), {63'd0, d_rvalid}, {63'd0, exp_drv[k]});
            n_resp += int'(f_rvalid) + int'(d_rvalid);
            step();
        end
        f_valid = 1'b0;
        d_valid = 1'b0;
        #1;
        check("alt_last_drv", {63'd0, d_rvalid}, 64'd1);
        check("alt_last_drdata", {32'd0, d_rdata}, 64'h0000_1111);
        n_resp += int'(f_rvalid) + int'(d_rvalid);
        check("alt_resp_count", 64'(n_resp), 64'd4);
        mem_rdata = '0;
        step();

        do_req("fetch",   1'b1, 1'b0, 3'b010, 9'h008, 32'h0, 32'h0055_a233, 1'b0);
        do_req("sw",      1'b0, 1'b1, 3'b010, 9'h00C, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0);
        do_req("lh_mis",  1'b0, 1'b0, 3'b001, 9'h003, 32'h0, 32'hAAAA_5555, 1'b1);
        do_req("lw_fe",   1'b0, 1'b0, 3'b010, 9'h0FE, 32'h0, 32'hAAAA_5555, 1'b1);
        do_req("lw_100",  1'b0, 1'b0, 3'b010, 9'h100, 32'h0, 32'hAAAA_5555, 1'b1);
        do_req("lw_fc",   1'b0, 1'b0, 3'b010, 9'h0FC, 32'h0, 32'hCAFE_F00D, 1'b0);
        do_req("lh_fe",   1'b0, 1'b0, 3'b001, 9'h0FE, 32'h0, 32'h0000_8001, 1'b0);
        do_req("lbu_ff",  1'b0, 1'b0, 3'b100, 9'h0FF, 32'h0, 32'h0000_00F0, 1'b0);
        do_req("f3_110",  1'b0, 1'b0, 3'b110, 9'h010, 32'h0, 32'hAAAA_5555, 1'b1);
        do_req("sh_101",  1'b0, 1'b1, 3'b101, 9'h010, 32'h1111_2222, 32'h0, 1'b1);
        do_req("f_mis",   1'b1, 1'b0, 3'b010, 9'h006, 32'h0, 32'h0BAD_0BAD, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Initiator-side controller that drives the single-ported unified instruction/data memory on behalf of the core. Accepts instruction-fetch and load/store requests over valid/ready handshakes and arbitrates between them round-robin. Issues one memory access per granted request, checks alignment and range, and returns read data or store acks with fixed latency. Sits between the fetch/LSU stages and the memory block; the memory itself owns data-region offsetting and load sign extension.

Parameters:
ADDR_W, 9, byte address width on all address ports
DATA_W, 32, data width
DATA_SPAN, 256, size in bytes of the data region; the memory adds the region base internally

Ports:
clk  in  1  core clock; all state updates on posedge
rst_n  in  1  synchronous, active-low reset
f_valid  in  1  fetch request valid
f_addr  in  ADDR_W  fetch byte address (PC)
f_ready  out  1  fetch request accepted this cycle when f_valid&f_ready
f_rvalid  out  1  fetch response pulse
f_rdata  out  DATA_W  fetched instruction
f_err  out  1  fetch misaligned (valid with f_rvalid)
d_valid  in  1  load/store request valid
d_we  in  1  1=store, 0=load
d_func3  in  3  RV32 width code (000 B, 001 H, 010 W, 100 BU, 101 HU)
d_addr  in  ADDR_W  data byte offset within data region
d_wdata  in  DATA_W  store data
d_ready  out  1  data request accepted when d_valid&d_ready
d_rvalid  out  1  data response pulse (load data or store ack)
d_rdata  out  DATA_W  load result (0 for stores and errors)
d_err  out  1  misaligned/out-of-range/illegal func3 (valid with d_rvalid)
mem_read  out  1  to memory MemRead
mem_write  out  1  to memory MemWrite
mem_fetch  out  1  1=instruction-region access
mem_addr  out  ADDR_W  to memory addr
mem_wdata  out  DATA_W  to memory data_in
mem_func3  out  3  to memory func3
mem_rdata  in  DATA_W  from memory data_out

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE, all outputs 0, last_grant=DATA so fetch wins first tie. In-flight request dropped; no memory strobe the cycle after reset.
- FSM: IDLE -> ACCESS on any accepted request; ACCESS -> IDLE always. Error requests also go through ACCESS with strobes held 0.
- f_ready = d_ready-side grant only in IDLE. Both valid: grant the one not granted last; otherwise grant the sole valid. Exactly one of f_ready/d_ready high per cycle.
- Accept cycle N: latch addr/func3/wdata/we/source. Cycle N+1 (ACCESS): drive mem_* from latches. mem_read=1 for load or fetch; mem_write=1 only for a legal store; mem_fetch=1 only for fetch. Fetch forces mem_func3=010. Outside ACCESS all mem_* are 0.
- Posedge ending ACCESS: capture mem_rdata. Cycle N+2: the matching rvalid is high for exactly one cycle with rdata/err. IDLE in N+2 may accept a new request the same cycle. Throughput is one request per 2 cycles.
- Checks, registered at accept: H/HU need addr[0]=0; W needs addr[1:0]=00. Range: addr+size-1 < DATA_SPAN. func3 outside {000,001,010,100,101}, and stores with func3>010, are illegal. Fetch needs f_addr[1:0]=00. On failure: no strobe, err=1, rdata=0.
- Store ack: d_rvalid=1, d_rdata=0, d_err=0.
- Inputs are not sampled while not ready; requester holds valid/fields stable until accepted.

Decomposition:
- Shared package mem_pkg: func3 constants F3_B/H/W/BU/HU, size-from-func3 function, grant enum {GNT_FETCH, GNT_DATA}, state enum {IDLE, ACCESS}.
- One sub-module, mem_req_check: combinational alignment/range/func3 legality, returns err. It is instantiated for both paths.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles mid-ACCESS -> all outputs 0; after release, first contested tie grants fetch.
- Fetch f_addr=0x008, mem_rdata=0x0055a233 -> mem_read=1, mem_fetch=1, mem_func3=010 at N+1; f_rvalid=1, f_rdata=0x0055a233 at N+2.
- SW d_addr=0x00C, d_wdata=0xDEADBEEF -> mem_write=1, mem_addr=0x00C at N+1; d_rvalid=1, d_err=0, d_rdata=0 at N+2.
- f_valid and d_valid held high for 8 cycles -> grants alternate F,D,F,D; 4 responses total, one every 2 cycles.
- LH d_addr=0x003 -> no strobes, d_err=1 at N+2. LW d_addr=0x0FE -> range error, d_err=1.
- func3=110 load, and SH with func3=101 -> d_err=1, mem_write stays 0.
